// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants.
// Bubble word, reset vector, IF/ID bundle and an alignment helper.
package if_stage_pkg;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC mux and +4 adder.
// Ports: clk_i, rst_i, stall_i, branch_taken_i, branch_target_i -> pc_o, pc_plus4_o.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc;
  logic [31:0] pc_next;

  // wraps mod 2^32
  assign pc_plus4_o = pc + 32'd4;
  assign pc_o       = pc;

  // redirect beats stall; a flush still advances the PC
  always_comb begin
    pc_next = pc_plus4_o;
    if (branch_taken_i) begin
      pc_next = word_align(branch_target_i);
    end else if (stall_i) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID register, misalign flag, fetch counter.
// Ports: clk_i, rst_i, stall_i, flush_i, branch_*, im_addr_o/im_data_i, IF/ID outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  if_id_t      if_id;
  if_id_t      bubble;

  assign bubble = '{instr: NOP, pc_plus4: 32'd0, valid: 1'b0};

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4)
  );

  assign im_addr_o  = pc;
  assign instr_o    = if_id.instr;
  assign pc_plus4_o = if_id.pc_plus4;
  assign valid_o    = if_id.valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_id         <= bubble;
      misalign_o    <= 1'b0;
      fetch_count_o <= 32'd0;
    end else if (branch_taken_i) begin
      if_id      <= bubble;
      misalign_o <= |branch_target_i[1:0];
    end else if (stall_i) begin
      misalign_o <= 1'b0;
    end else if (flush_i) begin
      if_id      <= bubble;
      misalign_o <= 1'b0;
    end else begin
      if_id         <= '{instr: im_data_i,
                         pc_plus4: pc_plus4,
                         valid: 1'b1};
      misalign_o    <= 1'b0;
      fetch_count_o <= fetch_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: inline instruction memory, rule-level model,
// per-cycle compare plus directed literal checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic [31:0] im_addr, im_data, instr, pp4, cnt;
  logic        valid, mis;

  logic [31:0] w_addr, w_data, w_instr, w_pp4, w_cnt;
  logic        w_valid, w_mis;

  int total = 0;
  int bad = 0;

  logic [31:0] rom [32];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:7] == 25'd0) return rom[a[6:2]];
    return {16'hBAD0, a[15:0]};
  endfunction

  assign im_data = mem_rd(im_addr);
  assign w_data  = mem_rd(w_addr);

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .branch_taken_i(br), .branch_target_i(tgt),
    .im_addr_o(im_addr), .im_data_i(im_data),
    .instr_o(instr), .pc_plus4_o(pp4), .valid_o(valid),
    .misalign_o(mis), .fetch_count_o(cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .flush_i(1'b0),
    .branch_taken_i(1'b0), .branch_target_i(32'd0),
    .im_addr_o(w_addr), .im_data_i(w_data),
    .instr_o(w_instr), .pc_plus4_o(w_pp4), .valid_o(w_valid),
    .misalign_o(w_mis), .fetch_count_o(w_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // model: what the fetch stage must hold, from the priority rules
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_mis;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'd0; m_instr <= 32'd0; m_pp4 <= 32'd0;
      m_valid <= 1'b0; m_mis <= 1'b0; m_cnt <= 32'd0;
      m_known <= 1'b1;
    end else if (br) begin
      m_pc <= tgt & ~32'd3;
      m_instr <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
      m_mis <= (tgt % 4) != 0;
    end else if (stall) begin
      m_mis <= 1'b0;
    end else if (flush) begin
      m_pc <= m_pc + 4;
      m_instr <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
      m_mis <= 1'b0;
    end else begin
      m_instr <= mem_rd(m_pc);
      m_pp4 <= m_pc + 4;
      m_pc <= m_pc + 4;
      m_valid <= 1'b1; m_mis <= 1'b0;
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("m_addr",  im_addr, m_pc);
      check("m_instr", instr, m_instr);
      check("m_pp4",   pp4, m_pp4);
      check("m_valid", {31'd0, valid}, {31'd0, m_valid});
      check("m_mis",   {31'd0, mis}, {31'd0, m_mis});
      check("m_cnt",   cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h2008_0001;
    rom[1] = 32'h2009_0002;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'hAC0A_0000;
    rom[4] = 32'h0800_0000;

    // reset for two edges
    tick(); tick();
    rst = 1'b0;
    check("rst_addr", im_addr, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_cnt", cnt, 32'd0);

    // two fetches, pc now 8
    tick();
    check("f0_instr", instr, 32'h2008_0001);
    check("f0_pp4", pp4, 32'h4);
    tick();
    check("f1_instr", instr, 32'h2009_0002);
    check("f1_pp4", pp4, 32'h8);

    // stall three cycles at pc 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_addr", im_addr, 32'h8);
      check("st_instr", instr, 32'h2009_0002);
      check("st_cnt", cnt, 32'd2);
    end
    stall = 1'b0;
    tick();
    check("f2_instr", instr, 32'h0109_5020);
    check("f2_pp4", pp4, 32'hC);
    tick();
    check("f3_instr", instr, 32'hAC0A_0000);
    tick();
    check("f4_instr", instr, 32'h0800_0000);
    check("f4_pp4", pp4, 32'h14);
    check("f4_cnt", cnt, 32'd5);

    // redirect to 0xC so pc reaches 0x10, then redirect to 0x4
    br = 1'b1; tgt = 32'hC;
    tick();
    br = 1'b0;
    tick();
    check("pre_addr", im_addr, 32'h10);
    br = 1'b1; tgt = 32'h4;
    tick();
    br = 1'b0;
    check("rd_valid", {31'd0, valid}, 32'd0);
    check("rd_instr", instr, 32'd0);
    check("rd_addr", im_addr, 32'h4);
    tick();
    check("rd_tinstr", instr, 32'h2009_0002);
    check("rd_tpp4", pp4, 32'h8);

    // all three controls: redirect wins
    br = 1'b1; stall = 1'b1; flush = 1'b1; tgt = 32'h0;
    tick();
    br = 1'b0; stall = 1'b0; flush = 1'b0;
    check("all_addr", im_addr, 32'h0);
    check("all_valid", {31'd0, valid}, 32'd0);
    tick();
    check("all_next", instr, 32'h2008_0001);

    // flush with stall: IF/ID holds
    flush = 1'b1; stall = 1'b1;
    tick();
    check("fs_instr", instr, 32'h2008_0001);
    check("fs_valid", {31'd0, valid}, 32'd1);
    check("fs_addr", im_addr, 32'h4);
    stall = 1'b0;
    tick();
    flush = 1'b0;
    check("fl_valid", {31'd0, valid}, 32'd0);
    check("fl_addr", im_addr, 32'h8);
    tick();
    check("fl_next", instr, 32'h0109_5020);

    // misaligned redirect
    br = 1'b1; tgt = 32'h6;
    tick();
    br = 1'b0;
    check("mis_addr", im_addr, 32'h4);
    check("mis_hi", {31'd0, mis}, 32'd1);
    tick();
    check("mis_lo", {31'd0, mis}, 32'd0);
    check("mis_instr", instr, 32'h2009_0002);

    // reset during a stall
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    check("mr_addr", im_addr, 32'd0);
    check("mr_valid", {31'd0, valid}, 32'd0);
    check("mr_cnt", cnt, 32'd0);
    check("mr_pp4", pp4, 32'd0);
    check("w_rst", w_addr, 32'hFFFF_FFFC);

    // wrap instance: one fetch from the last word
    tick();
    check("w_pp4", w_pp4, 32'd0);
    check("w_addr", w_addr, 32'd0);
    check("w_valid", {31'd0, w_valid}, 32'd1);
    check("w_instr", w_instr, 32'hBAD0_FFFC);
    check("w_cnt", w_cnt, 32'd1);
    tick();
    check("w_next", w_instr, 32'h2008_0001);
    check("w_mis", {31'd0, w_mis}, 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
